// File: rtl/alu_rr_ctrl.sv
// alu_rr_ctrl
//   Round-robin controller sharing one 64-bit Y86-64 ALU (add/sub/and/xor)
//   between two requesters. A request is accepted in IDLE, the operation
//   runs in EXEC, and the tagged result is presented in RESP until the
//   consumer takes it.
//
//   Optional feature macro: ALU_CC_EN
//     defined   -> ZF/SF/OF condition-code register, updated on every op
//     undefined -> no CC flops, cc_zf/cc_sf/cc_of tied to 0
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
//   both valid and ready are high. A producer holds valid and its payload
//   stable until that edge; ready may depend combinationally on valid.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake for requester N (0/1)
//   reqN_op                     0 add, 1 sub (b-a), 2 and, 3 xor
//   reqN_a, reqN_b              operands
//   rsp_valid/ready             response handshake
//   rsp_id                      requester that owns the result
//   rsp_result                  result
//   cc_zf, cc_sf, cc_of         condition codes
//   dbg_state                   FSM state (0 IDLE, 1 EXEC, 2 RESP)
module alu_rr_ctrl #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  logic         last_grant;  // requester granted most recently
  logic [1:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         grant0;
  logic         grant1;
  logic [W-1:0] alu_r;

  // On a tie, the requester that was not granted last wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  // Gated with rst_n so both readies read 0 while reset is held.
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign dbg_state  = state;

  // Subtraction follows Y86 subq: the first operand is subtracted from the second.
  always_comb begin
    alu_r = '0;
    case (op_q)
      2'd0:    alu_r = a_q + b_q;
      2'd1:    alu_r = b_q - a_q;
      2'd2:    alu_r = a_q & b_q;
      default: alu_r = a_q ^ b_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= 2'd0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0) begin
            op_q   <= req0_op;
            a_q    <= req0_a;
            b_q    <= req0_b;
            rsp_id <= 1'b0;
            state  <= EXEC;
          end else if (grant1) begin
            op_q   <= req1_op;
            a_q    <= req1_a;
            b_q    <= req1_b;
            rsp_id <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_r;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_CC_EN
  logic alu_of;

  // Signed overflow: add when same-sign operands give a different-sign
  // result; sub (b-a) when operand signs differ and the result sign
  // departs from b. Logic ops never overflow.
  always_comb begin
    alu_of = 1'b0;
    case (op_q)
      2'd0:    alu_of = (a_q[W-1] == b_q[W-1]) && (alu_r[W-1] != a_q[W-1]);
      2'd1:    alu_of = (a_q[W-1] != b_q[W-1]) && (alu_r[W-1] != b_q[W-1]);
      default: alu_of = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (state == EXEC) begin
      cc_zf <= (alu_r == '0);
      cc_sf <= alu_r[W-1];
      cc_of <= alu_of;
    end
  end
`else
  assign cc_zf = 1'b0;
  assign cc_sf = 1'b0;
  assign cc_of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_rr_ctrl.sv
module tb_alu_rr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [63:0] rsp_result;
  logic        cc_zf, cc_sf, cc_of;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // reference-model state
  logic        last_m;           // requester granted last
  logic        zf_m, sf_m, of_m; // architectural CC after last completed op
  logic [63:0] exp_q[$];         // expected results, in acceptance order
  logic [63:0] obs_result;
  logic        obs_id;

  alu_rr_ctrl #(.W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_res(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return b - a;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Overflow = the exact signed answer does not fit in 64 signed bits.
  function automatic logic model_of(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [65:0] ea, eb, ex, er;
    logic [63:0] r;
    ea = $signed({{2{a[63]}}, a});
    eb = $signed({{2{b[63]}}, b});
    if (op == 2'd0)      ex = ea + eb;
    else if (op == 2'd1) ex = eb - ea;
    else                 return 1'b0;
    r  = ex[63:0];
    er = $signed({{2{r[63]}}, r});
    return ex != er;
  endfunction

  task automatic model_reset();
    last_m = 1'b1;
`ifdef ALU_CC_EN
    zf_m = 1'b1;
`else
    zf_m = 1'b0;
`endif
    sf_m = 1'b0;
    of_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 0;
  endtask

  // ---------------- driver + checks for one transaction ----------------
  // Entered at a negedge with the DUT idle. Requests stay valid until the
  // response handshake; hold = cycles of rsp_ready=0 in RESP.
  task automatic txn(input logic v0, input logic v1,
                     input logic [1:0] o0, input logic [63:0] a0, input logic [63:0] b0,
                     input logic [1:0] o1, input logic [63:0] a1, input logic [63:0] b1,
                     input int hold);
    logic win;
    logic [1:0] eop;
    logic [63:0] ea, eb, er;
    win = (v0 && v1) ? !last_m : !v0;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready = 0;
    #1;
    checks++;
    if (req0_ready !== (win == 1'b0) || req1_ready !== (win == 1'b1)) begin
      errors++;
      $display("FAIL grant: ready0/1=%b%b expected %b%b", req0_ready, req1_ready, win == 1'b0, win == 1'b1);
    end
    eop = win ? o1 : o0;
    ea  = win ? a1 : a0;
    eb  = win ? b1 : b0;
    exp_q.push_back(model_res(eop, ea, eb));
    @(posedge clk);
    @(negedge clk);
    // EXEC: nothing visible yet, no second grant
    checks++;
    if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL exec_cycle: rsp_valid=%b ready=%b%b expected 0 00", rsp_valid, req0_ready, req1_ready);
    end
    @(negedge clk);
    er = exp_q.pop_front();
`ifdef ALU_CC_EN
    zf_m = (er == 64'd0);
    sf_m = er[63];
    of_m = model_of(eop, ea, eb);
`endif
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== win || rsp_result !== er) begin
      errors++;
      $display("FAIL response: valid=%b id=%b result=%h expected 1 %b %h", rsp_valid, rsp_id, rsp_result, win, er);
    end
    checks++;
    if (cc_zf !== zf_m || cc_sf !== sf_m || cc_of !== of_m) begin
      errors++;
      $display("FAIL cc: zf/sf/of=%b%b%b expected %b%b%b", cc_zf, cc_sf, cc_of, zf_m, sf_m, of_m);
    end
    obs_result = rsp_result;
    obs_id     = rsp_id;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== win || rsp_result !== er ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure: valid=%b id=%b result=%h ready=%b%b expected 1 %b %h 00",
                 rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready, win, er);
      end
    end
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    last_m = win;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_drop: rsp_valid=%b expected 0", rsp_valid);
    end
    req0_valid = 0;
    req1_valid = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic exp_zf;
`ifdef ALU_CC_EN
    exp_zf = 1'b1;
`else
    exp_zf = 1'b0;
`endif
    checks++;
    if (req0_ready !== 0 || req1_ready !== 0 || rsp_valid !== 0 || rsp_id !== 0 ||
        rsp_result !== 64'd0 || cc_zf !== exp_zf || cc_sf !== 0 || cc_of !== 0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b%b v=%b id=%b r=%h cc=%b%b%b expected 00 0 0 0 %b00",
               req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, cc_zf, cc_sf, cc_of, exp_zf);
    end
  endtask

  task automatic test_add();
    txn(1, 0, 2'd0, 64'd20, 64'd50, 2'd0, 64'd0, 64'd0, 0);
    checks++;
    if (obs_result !== 64'd70 || obs_id !== 1'b0) begin
      errors++;
      $display("FAIL add_result: %h id=%b expected 70 id=0", obs_result, obs_id);
    end
  endtask

  task automatic test_sub();
    txn(0, 1, 2'd0, 64'd0, 64'd0, 2'd1, 64'd50, 64'd20, 0);
    checks++;
    if (obs_result !== 64'hFFFF_FFFF_FFFF_FFE2 || obs_id !== 1'b1) begin
      errors++;
      $display("FAIL sub_result: %h id=%b expected ffffffffffffffe2 id=1", obs_result, obs_id);
    end
  endtask

  task automatic test_ovf_logic();
    txn(1, 0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 2'd0, 64'd0, 64'd0, 0);
    checks++;
    if (obs_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL add_ovf_result: %h expected fffffffffffffffe", obs_result);
    end
    txn(1, 0, 2'd2, 64'd20, 64'd50, 2'd0, 64'd0, 64'd0, 0);
    checks++;
    if (obs_result !== 64'd16) begin
      errors++;
      $display("FAIL and_result: %h expected 10", obs_result);
    end
    txn(0, 1, 2'd0, 64'd0, 64'd0, 2'd3, 64'd5, 64'd5, 0);
    checks++;
    if (obs_result !== 64'd0) begin
      errors++;
      $display("FAIL xor_result: %h expected 0", obs_result);
    end
    // signed sub overflow: 5 - (-2^63)
    txn(1, 0, 2'd1, 64'h8000_0000_0000_0000, 64'd5, 2'd0, 64'd0, 64'd0, 0);
  endtask

  task automatic test_arbitration();
    for (int i = 0; i < 4; i++)
      txn(1, 1, 2'd0, 64'(i), 64'd1, 2'd3, 64'(i), 64'hFF, 0);
  endtask

  task automatic test_backpressure();
    txn(1, 1, 2'd1, 64'd7, 64'd3, 2'd0, 64'd9, 64'd9, 3);
    txn(1, 1, 2'd2, 64'hF0F0, 64'hFF00, 2'd3, 64'h1, 64'h3, 2);
  endtask

  task automatic test_reset_mid_op();
    logic exp_zf;
`ifdef ALU_CC_EN
    exp_zf = 1'b1;
`else
    exp_zf = 1'b0;
`endif
    req0_valid = 1; req0_op = 2'd0; req0_a = 64'd1; req0_b = 64'd2;
    req1_valid = 1; req1_op = 2'd3; req1_a = 64'd3; req1_b = 64'd4;
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req0_ready !== 0 || req1_ready !== 0 || rsp_valid !== 0 || rsp_id !== 0 ||
          rsp_result !== 64'd0 || cc_zf !== exp_zf || cc_sf !== 0 || cc_of !== 0) begin
        errors++;
        $display("FAIL reset_mid_op: rdy=%b%b v=%b id=%b r=%h cc=%b%b%b expected 00 0 0 0 %b00",
                 req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, cc_zf, cc_sf, cc_of, exp_zf);
      end
      @(negedge clk);
    end
    idle_inputs();
    rst_n = 1;
    model_reset();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_stale_rsp: rsp_valid=%b expected 0", rsp_valid);
    end
    // first tie after reset goes to req0
    txn(1, 1, 2'd0, 64'd11, 64'd22, 2'd1, 64'd1, 64'd2, 0);
    checks++;
    if (obs_id !== 1'b0) begin
      errors++;
      $display("FAIL tie_after_reset: id=%b expected 0", obs_id);
    end
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random();
    int sel;
    logic [63:0] a0, b0, a1, b1;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 3);
      a0 = rand_operand(); b0 = rand_operand();
      a1 = rand_operand(); b1 = ($urandom_range(0, 4) == 0) ? a1 : rand_operand();
      txn(sel[0], sel[1], 2'($urandom_range(0, 3)), a0, b0,
          2'($urandom_range(0, 3)), a1, b1, $urandom_range(0, 3));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1;
    @(negedge clk);
    test_add();
    test_sub();
    test_ovf_logic();
    test_arbitration();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rr_ctrl.md
# alu_rr_ctrl

Round-robin controller that shares one 64-bit Y86-64 ALU (add/sub/and/xor) between two requesters in the execute stage. Each requester uses a valid/ready handshake to present an operation and two operands. The block arbitrates, runs the operation, and returns the tagged result through a valid/ready response port. Optionally it keeps the Y86 condition-code register (ZF/SF/OF).

## Interface
- W, 64, operand/result width (only 64 is supported)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid, req1_valid  in  1  request present
- req0_ready, req1_ready  out  1  request accepted on this edge when valid is also high
- req0_op, req1_op  in  2  op code: 0 = add, 1 = sub, 2 = and, 3 = xor
- req0_a, req0_b, req1_a, req1_b  in  W  operands
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  1  index of the requester that owns the result
- rsp_result  out  W  result
- cc_zf, cc_sf, cc_of  out  1  condition codes

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - reqN_ready = 1 only for the granted requester, and only when at least one requester is valid.
  - Grant rule: if exactly one requester is valid, grant it. If both are valid, grant the one that was not granted last (round-robin).
  - The last-grant pointer resets to 1, so req0 wins the first tie.
  - On accept, op, a, b and id are latched and the FSM goes to EXEC.
- EXEC:
  - result = a+b (op 0), b−a (op 1, Y86 subq semantics), a&b (op 2), a^b (op 3). Arithmetic is modulo 2^64.
  - The result is registered, the CC is updated (when configured), and the FSM goes to RESP.
- RESP:
  - rsp_valid = 1. rsp_id and rsp_result are held stable.
  - When rsp_ready = 1: return to IDLE and update the last-grant pointer to rsp_id.
- Overflow flag:
  - add: OF = (a[63] == b[63]) && (r[63] != a[63])
  - sub: OF = (a[63] != b[63]) && (r[63] != b[63])
  - and/xor: OF = 0
- Other flags: ZF = (r == 0), SF = r[63].
- Both ready outputs are 0 outside IDLE. A request held valid in those states waits; it is never dropped.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and any in-flight result is discarded (no rsp_valid).
- Reset values:
  - req*_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 0
  - cc_zf = 1, cc_sf = 0, cc_of = 0

## Timing
- Accept edge is cycle N. EXEC occupies N+1. rsp_valid is first high in cycle N+2.
- Minimum latency from accept to response is 2 cycles. Peak throughput is one operation per 3 cycles.
- Ready outputs are combinational from req*_valid, the FSM state and the pointer. Every other output is registered.
- CC outputs change on the EXEC→RESP edge. They are therefore valid in the same cycle rsp_valid first rises, and stay valid until the next EXEC.
- rsp_valid stays high with stable data until rsp_ready is sampled high. It deasserts on the following cycle.
- The earliest the next accept can happen is the cycle after the response handshake.

## Configuration
- ALU_CC_EN defined: the CC register is implemented as described above and updated on every operation.
- ALU_CC_EN undefined: no CC flops. cc_zf, cc_sf and cc_of are tied to 0. All other behaviour is unchanged.

## Test plan
- **Add:** after reset, req0 add a=20, b=50, rsp_ready = 1.
  - Expect rsp_valid 2 cycles after accept, rsp_id = 0, result = 70, ZF/SF/OF = 0/0/0.
- **Sub:** req1 sub a=50, b=20.
  - Expect result = 0xFFFFFFFFFFFFFFE2, rsp_id = 1, SF = 1, ZF = 0, OF = 0.
- **Add overflow and logic ops:** add a = b = 0x7FFFFFFFFFFFFFFF.
  - Expect result 0xFFFFFFFFFFFFFFFE, OF = 1, SF = 1.
  - Then: and a=20, b=50 → result 16, ZF = 0; xor a=b=5 → result 0, ZF = 1, OF = 0.
- **Arbitration:** both requesters held valid continuously from reset.
  - Expect grant order req0, req1, req0, req1, with each ready pulse lasting exactly 1 cycle.
- **Backpressure:** hold rsp_ready = 0 for 3 cycles in RESP.
  - Expect rsp_valid, rsp_id and rsp_result stable, both ready outputs = 0, and a new request not accepted until after the handshake.
- **Reset mid-operation:** assert rst_n = 0 during EXEC.
  - Expect all outputs at reset values and no response.
  - A subsequent tie must grant req0 first.
